tristate_bus_arbiter: RTL and testbench

TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

---
 rtl/tristate_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tristate_bus_arbiter.sv
// Four-requester round-robin owner of a shared tri-state bus with a high-Z turnaround between owners.
// Optional tenure limit is compiled in with the TRISTATE_TENURE_LIMIT_EN macro.
module tristate_bus_arbiter #(
   parameter int DW      = 8,
   parameter int TURN    = 1,
   parameter int MAXHOLD = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] din,
   output logic [3:0]      gnt,
   output logic [3:0]      en,
   output logic [1:0]      owner,
   output logic            busy_own,
   output tri   [DW-1:0]   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);
   localparam logic [2:0] TURN_C    = 3'(TURN);

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    owner_q, owner_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [3:0]    en_q, en_d;
   logic          busy_q, busy_d;
   logic [7:0]    ten_q, ten_d;
   logic [2:0]    tcnt_q, tcnt_d;
   logic [1:0]    sel_s;
   logic          sel_vld_s;
   logic          limit_hit_s;
   logic [DW-1:0] owner_data_s;

`ifdef TRISTATE_TENURE_LIMIT_EN
   assign limit_hit_s = (ten_q >= MAXHOLD_C);
`else
   assign limit_hit_s = 1'b0;
`endif

   // Round-robin pick: scan downward so the set bit closest to ptr_q is written last and wins.
   always_comb begin
      sel_vld_s = 1'b0;
      sel_s     = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req[ptr_q + 2'(k)]) begin
            sel_vld_s = 1'b1;
            sel_s     = ptr_q + 2'(k);
         end else begin
            sel_vld_s = sel_vld_s;
         end
      end
   end

   // Next-state and next-output computation for the IDLE/OWN/TURN sequencer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      en_d    = en_q;
      busy_d  = busy_q;
      ten_d   = ten_q;
      tcnt_d  = tcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_vld_s) begin
               state_d = ST_OWN;
               owner_d = sel_s;
               gnt_d   = onehot4(sel_s);
               en_d    = onehot4(sel_s);
               busy_d  = 1'b1;
               ten_d   = 8'd1;
            end else begin
               gnt_d  = 4'b0000;
               en_d   = 4'b0000;
               busy_d = 1'b0;
            end
         end
         ST_OWN: begin
            if (!req[owner_q] || limit_hit_s) begin
               state_d = ST_TURN;
               gnt_d   = 4'b0000;
               en_d    = 4'b0000;
               busy_d  = 1'b0;
               ptr_d   = owner_q + 2'd1;
               ten_d   = 8'd0;
               tcnt_d  = 3'd1;
            end else begin
               ten_d = (ten_q < MAXHOLD_C) ? ten_q + 8'd1 : ten_q;
            end
         end
         ST_TURN: begin
            if (tcnt_q >= TURN_C) begin
               state_d = ST_IDLE;
               tcnt_d  = 3'd0;
            end else begin
               tcnt_d = tcnt_q + 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            en_d    = 4'b0000;
            busy_d  = 1'b0;
            ten_d   = 8'd0;
            tcnt_d  = 3'd0;
         end
      endcase
   end

   // State and output registers; reset releases the bus immediately with no turnaround.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         owner_q <= 2'd0;
         gnt_q   <= 4'b0000;
         en_q    <= 4'b0000;
         busy_q  <= 1'b0;
         ten_q   <= 8'd0;
         tcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         ten_q   <= ten_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Data slice of the current owner, driven onto the bus only while owned.
   always_comb begin
      case (owner_q)
         2'd0:    owner_data_s = din[0*DW +: DW];
         2'd1:    owner_data_s = din[1*DW +: DW];
         2'd2:    owner_data_s = din[2*DW +: DW];
         2'd3:    owner_data_s = din[3*DW +: DW];
         default: owner_data_s = {DW{1'b0}};
      endcase
   end

   assign bus      = busy_q ? owner_data_s : {DW{1'bz}};
   assign gnt      = gnt_q;
   assign en       = en_q;
   assign owner    = owner_q;
   assign busy_own = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter; tenure scenario selected by TRISTATE_TENURE_LIMIT_EN.
`timescale 1ns/1ps
module tb_tristate_bus_arbiter;
   localparam int DW = 8;
`ifdef TRISTATE_TENURE_LIMIT_EN
   localparam int MH   = 4;
   localparam int HOLD = 3;
`else
   localparam int MH   = 16;
   localparam int HOLD = 10;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req = 4'b0000;
   logic [4*DW-1:0] din = {8'h44, 8'h33, 8'h22, 8'h11};
   logic [3:0]    gnt;
   logic [3:0]    en;
   logic [1:0]    owner;
   logic          busy_own;
   wire  [DW-1:0] bus;
   int tests_run = 0;
   int tests_failed = 0;

   tristate_bus_arbiter #(.DW(DW), .TURN(1), .MAXHOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .din(din),
      .gnt(gnt), .en(en), .owner(owner), .busy_own(busy_own), .bus(bus)
   );

   always #5 clk = ~clk;

   // Every-cycle contention watch.
   always @(negedge clk) begin
      tests_run++;
      if ($countones(en) > 1 || en !== gnt) begin
         tests_failed++;
         $display("FAIL contention: en=%b gnt=%b", en, gnt);
      end
      if (busy_own === 1'b1) begin
         tests_run++;
         if ($isunknown(bus)) begin
            tests_failed++;
            $display("FAIL bus_unknown: bus=%h while owned", bus);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (gnt !== 4'b0000 || en !== 4'b0000 || owner !== 2'd0 || busy_own !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: gnt=%b en=%b owner=%0d busy=%b, want 0000 0000 0 0", gnt, en, owner, busy_own);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      din[2*DW +: DW] = 8'hA5;
      req = 4'b0100;
      step();
      tests_run++;
      if (gnt !== 4'b0100 || en !== 4'b0100 || owner !== 2'd2 || busy_own !== 1'b1 || bus !== 8'hA5) begin
         tests_failed++;
         $display("FAIL single_grant: gnt=%b en=%b owner=%0d busy=%b bus=%h, want 0100 0100 2 1 a5", gnt, en, owner, busy_own, bus);
      end
      din[2*DW +: DW] = 8'h3C;
      #1;
      tests_run++;
      if (bus !== 8'h3C) begin
         tests_failed++;
         $display("FAIL single_comb_bus: bus=%h, want 3c", bus);
      end
      req = 4'b0000;
      step();
      tests_run++;
      if (gnt !== 4'b0000 || en !== 4'b0000 || busy_own !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_turn: gnt=%b en=%b busy=%b, want released", gnt, en, busy_own);
      end
      step();
      tests_run++;
      if (gnt !== 4'b0000 || busy_own !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_idle: gnt=%b busy=%b, want idle", gnt, busy_own);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_order [5];
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req = 4'b1111;
      step();
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (owner !== exp_order[i] || gnt !== (4'b0001 << exp_order[i]) || busy_own !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_order[%0d]: owner=%0d gnt=%b, want owner %0d", i, owner, gnt, exp_order[i]);
         end
         req = 4'b1111 & ~(4'b0001 << exp_order[i]);
         step();
         tests_run++;
         if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rr_turn[%0d]: gnt=%b, want 0000", i, gnt);
         end
         req = 4'b1111;
         step();
         tests_run++;
         if (gnt !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rr_idle[%0d]: gnt=%b, want 0000", i, gnt);
         end
         step();
      end
      req = 4'b0000;
   endtask

   task automatic test_no_preempt();
      do_reset();
      din[1*DW +: DW] = 8'h5A;
      req = 4'b0010;
      step();
      req = 4'b1010;
      for (int i = 0; i < HOLD; i++) begin
         tests_run++;
         if (gnt !== 4'b0010 || bus !== 8'h5A) begin
            tests_failed++;
            $display("FAIL nopre_hold[%0d]: gnt=%b bus=%h, want 0010 5a", i, gnt, bus);
         end
         if (i < HOLD - 1) step();
      end
      req = 4'b1000;
      step();
      tests_run++;
      if (gnt !== 4'b0000) begin
         tests_failed++;
         $display("FAIL nopre_gap1: gnt=%b, want 0000", gnt);
      end
      step();
      tests_run++;
      if (gnt !== 4'b0000) begin
         tests_failed++;
         $display("FAIL nopre_gap2: gnt=%b, want 0000", gnt);
      end
      step();
      tests_run++;
      if (gnt !== 4'b1000 || owner !== 2'd3) begin
         tests_failed++;
         $display("FAIL nopre_next: gnt=%b owner=%0d, want 1000 3", gnt, owner);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_tenure();
      logic [3:0] exp_gnt [13];
`ifdef TRISTATE_TENURE_LIMIT_EN
      exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
`else
      exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                  4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 13; i++) begin
         step();
         tests_run++;
         if (gnt !== exp_gnt[i]) begin
            tests_failed++;
            $display("FAIL tenure[%0d]: gnt=%b, want %b", i, gnt, exp_gnt[i]);
         end
      end
      req = 4'b0000;
   endtask

   task automatic test_pulse();
      do_reset();
      req = 4'b0001;
      #2;
      req = 4'b0000;
      step();
      tests_run++;
      if (gnt !== 4'b0000) begin
         tests_failed++;
         $display("FAIL pulse_dropped: gnt=%b, want 0000", gnt);
      end
      req = 4'b1000;
      step();
      req = 4'b0000;
      tests_run++;
      if (gnt !== 4'b1000) begin
         tests_failed++;
         $display("FAIL pulse_grant: gnt=%b, want 1000", gnt);
      end
      step();
      tests_run++;
      if (gnt !== 4'b0000 || busy_own !== 1'b0) begin
         tests_failed++;
         $display("FAIL pulse_release: gnt=%b busy=%b, want 0000 0", gnt, busy_own);
      end
      step();
   endtask

   task automatic test_reset_mid_own();
      req = 4'b0001;
      step();
      tests_run++;
      if (gnt !== 4'b0001) begin
         tests_failed++;
         $display("FAIL rst_pre_own: gnt=%b, want 0001", gnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (gnt !== 4'b0000 || en !== 4'b0000 || busy_own !== 1'b0 || owner !== 2'd0) begin
         tests_failed++;
         $display("FAIL rst_mid_own: gnt=%b en=%b busy=%b owner=%0d, want released", gnt, en, busy_own, owner);
      end
      #2;
      rst_n = 1'b1;
      step();
      tests_run++;
      if (gnt !== 4'b0001 || busy_own !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_first_arb: gnt=%b busy=%b, want 0001 1", gnt, busy_own);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_no_preempt();
      test_tenure();
      test_pulse();
      test_reset_mid_own();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
